interface_hcsr04_auto: RTL

INTERFACE_HCSR04_AUTO -- requirements
Module: interface_hcsr04_auto

---
 rtl/interface_hcsr04_auto.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/interface_hcsr04_auto.sv
// ---------------------------------------------------------------------------
// interface_hcsr04_auto
//
// Controller for an HC-SR04 ultrasonic ranging sensor. On request it fires a
// trigger pulse, waits for the echo pulse, and measures how long echo stays
// high. The echo-high time is converted to whole centimetres and rounded to
// the nearest centimetre. Every measurement attempt is followed by an idle
// hold-off gap. In continuous mode the controller re-triggers by itself after
// each hold-off.
//
// Parameters
//   TRIG_CLKS     trigger pulse width in clocks
//   CM_CLKS       echo-high clocks per centimetre
//   W             width of the distance output
//   TIMEOUT_CLKS  clocks allowed from WAIT_ECHO entry until echo falls
//   HOLDOFF_CLKS  idle gap in clocks after every attempt
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   medir      in   request one measurement (honoured only while idle)
//   continuo   in   continuous mode, sampled at the end of hold-off
//   echo       in   sensor echo, asynchronous to clock
//   trigger    out  registered trigger pulse to the sensor
//   distancia  out  last valid distance in centimetres
//   pronto     out  one-cycle pulse when an attempt finishes
//   timeout    out  last attempt ended without a complete echo
//   ocupado    out  controller is not idle
// ---------------------------------------------------------------------------
module interface_hcsr04_auto #(
    parameter int TRIG_CLKS    = 500,
    parameter int CM_CLKS      = 2941,
    parameter int W            = 12,
    parameter int TIMEOUT_CLKS = 2000000,
    parameter int HOLDOFF_CLKS = 3000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         medir,
    input  logic         continuo,
    input  logic         echo,
    output logic         trigger,
    output logic [W-1:0] distancia,
    output logic         pronto,
    output logic         timeout,
    output logic         ocupado
);

    localparam int TRIG_W = $clog2(TRIG_CLKS + 1);
    localparam int RES_W  = $clog2(CM_CLKS + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam int HO_W   = $clog2(HOLDOFF_CLKS + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        STORE     = 3'd4,
        HOLDOFF   = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    logic              echo_meta;
    logic              echo_sync;
    logic              armed;
    logic [TRIG_W-1:0] trig_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [HO_W-1:0]   hold_cnt;
    logic [RES_W-1:0]  residual;
    logic [W-1:0]      cm;
    logic [W-1:0]      rounded;
    logic              trig_done;
    logic              to_hit;
    logic              hold_done;
    logic              timeout_evt;
    logic              count_step;

    // Two-flop synchronizer for the asynchronous echo line. Every echo
    // decision below uses echo_sync only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;
        end
    end

    assign trig_done   = (trig_cnt == TRIG_W'(TRIG_CLKS - 1));
    assign to_hit      = (to_cnt == TO_W'(TIMEOUT_CLKS - 1));
    assign hold_done   = (hold_cnt == HO_W'(HOLDOFF_CLKS - 1));
    assign timeout_evt = ((state == WAIT_ECHO) || (state == MEASURE)) && to_hit;

    // A sample is counted on the cycle that starts MEASURE and on every
    // following MEASURE cycle where echo is still high, so the counted total
    // equals the number of high echo_sync samples.
    assign count_step  = ((state == WAIT_ECHO) || (state == MEASURE)) && (next_state == MEASURE);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The timeout has priority over echo activity so an
    // attempt can never run past TIMEOUT_CLKS.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (medir) begin
                    next_state = TRIG;
                end
            end
            TRIG: begin
                if (trig_done) begin
                    next_state = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                if (to_hit) begin
                    next_state = HOLDOFF;
                end else if (armed && echo_sync) begin
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                if (to_hit) begin
                    next_state = HOLDOFF;
                end else if (!echo_sync) begin
                    next_state = STORE;
                end
            end
            STORE: begin
                next_state = HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_done) begin
                    next_state = continuo ? TRIG : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Phase counters. Each one runs only inside its own phase and is cleared
    // elsewhere, so every phase starts counting from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_cnt <= '0;
            to_cnt   <= '0;
            hold_cnt <= '0;
        end else begin
            if (state == TRIG) begin
                trig_cnt <= trig_cnt + 1'b1;
            end else begin
                trig_cnt <= '0;
            end

            if ((state == WAIT_ECHO) || (state == MEASURE)) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (state == HOLDOFF) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // Echo must be seen low inside WAIT_ECHO before a high level can start a
    // measurement; an echo that is already high on entry is stale.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
        end else begin
            armed <= (state == WAIT_ECHO) && (armed || !echo_sync);
        end
    end

    // Distance accumulation: residual counts clocks within the current
    // centimetre, cm counts completed centimetres and sticks at its maximum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            residual <= '0;
            cm       <= '0;
        end else if (count_step) begin
            if (residual == RES_W'(CM_CLKS - 1)) begin
                residual <= '0;
                if (cm != '1) begin
                    cm <= cm + 1'b1;
                end
            end else begin
                residual <= residual + 1'b1;
            end
        end else if (state == WAIT_ECHO) begin
            residual <= '0;
            cm       <= '0;
        end
    end

    // Round to nearest centimetre: a residual of at least half a centimetre
    // bumps the result by one, without passing the maximum code.
    always_comb begin
        rounded = cm;
        if ((residual >= RES_W'(CM_CLKS / 2)) && (cm != '1)) begin
            rounded = cm + 1'b1;
        end
    end

    // Registered outputs. trigger and ocupado follow the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trigger   <= 1'b0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            timeout   <= 1'b0;
            distancia <= '0;
        end else begin
            trigger <= (next_state == TRIG);
            ocupado <= (next_state != IDLE);
            pronto  <= (state == STORE) || timeout_evt;
            if (state == STORE) begin
                distancia <= rounded;
                timeout   <= 1'b0;
            end else if (timeout_evt) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
